// File: rtl/axi_line_mem_responder_if.sv
// AXI4 bundle between the interconnect's memory-side initiator (master) and the line memory responder (slave).
interface axi_line_mem_responder_if #(
  parameter int ID_WIDTH   = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi_line_mem_responder.sv
// Single-transaction AXI4 main-memory model serving line reads/write-backs from a word array.
// Define AXI_LINE_MEM_RR_ARB_EN for round-robin read/write arbitration; otherwise reads always win.
module axi_line_mem_responder #(
  parameter int ID_WIDTH       = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int BYTES_PER_LINE = 16,
  parameter int MEM_LINES      = 1024
) (
  input  logic clk,
  input  logic rst,
  axi_line_mem_responder_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SHIFT      = $clog2(STRB_WIDTH);
  localparam int MEM_WORDS  = MEM_LINES * BYTES_PER_LINE / STRB_WIDTH;
  localparam int IDX_W      = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, RD_DATA, WR_DATA, WR_RESP} state_t;

  state_t                state, next_state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [IDX_W-1:0]      base_q;
  logic [7:0]            len_q;
  logic [1:0]            status_q;
  logic [8:0]            beat_q;
  logic                  prefer_read;
  logic                  grant_read, grant_write;
  logic                  at_len, wr_en;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // The whole burst is range-checked up front so the data phase only consults the latched status.
  function automatic logic [1:0] classify(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH:0] last_idx;
    last_idx = {1'b0, addr >> SHIFT} + (ADDR_WIDTH+1)'(len);
    if (last_idx >= LIMIT) return RESP_DECERR;
    if (size != 3'(SHIFT) || burst != 2'b01) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

`ifdef AXI_LINE_MEM_RR_ARB_EN
  logic last_was_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_was_write <= 1'b1;
    else if (grant_read) last_was_write <= 1'b0;
    else if (grant_write) last_was_write <= 1'b1;
  end

  assign prefer_read = last_was_write;
`else
  assign prefer_read = 1'b1;
`endif

  assign grant_read  = (state == IDLE) && !rst && bus.arvalid && (prefer_read || !bus.awvalid);
  assign grant_write = (state == IDLE) && !rst && bus.awvalid && !grant_read;
  assign at_len      = (beat_q == {1'b0, len_q});
  assign mem_idx     = base_q + IDX_W'(beat_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= next_state;
  end

  always_comb begin
    next_state  = state;
    bus.arready = 1'b0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rid     = '0;
    bus.rdata   = '0;
    bus.rresp   = '0;
    bus.rlast   = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bid     = '0;
    bus.bresp   = '0;
    wr_en       = 1'b0;
    case (state)
      IDLE: begin
        bus.arready = grant_read;
        bus.awready = grant_write;
        if (grant_read) next_state = RD_DATA;
        else if (grant_write) next_state = WR_DATA;
      end
      RD_DATA: begin
        bus.rvalid = 1'b1;
        bus.rid    = id_q;
        bus.rresp  = status_q;
        bus.rlast  = at_len;
        bus.rdata  = (status_q == RESP_OKAY) ? mem[mem_idx] : '0;
        if (bus.rready && at_len) next_state = IDLE;
      end
      WR_DATA: begin
        bus.wready = 1'b1;
        if (bus.wvalid) begin
          // A short burst's final beat is already known to be in error, so it must not land.
          wr_en = (status_q == RESP_OKAY) && (beat_q <= {1'b0, len_q}) && !(bus.wlast && !at_len);
          if (bus.wlast) next_state = WR_RESP;
        end
      end
      WR_RESP: begin
        bus.bvalid = 1'b1;
        bus.bid    = id_q;
        bus.bresp  = status_q;
        if (bus.bready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q     <= '0;
      base_q   <= '0;
      len_q    <= '0;
      status_q <= RESP_OKAY;
      beat_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_read) begin
            id_q     <= bus.arid;
            base_q   <= IDX_W'(bus.araddr >> SHIFT);
            len_q    <= bus.arlen;
            status_q <= classify(bus.araddr, bus.arlen, bus.arsize, bus.arburst);
            beat_q   <= '0;
          end else if (grant_write) begin
            id_q     <= bus.awid;
            base_q   <= IDX_W'(bus.awaddr >> SHIFT);
            len_q    <= bus.awlen;
            status_q <= classify(bus.awaddr, bus.awlen, bus.awsize, bus.awburst);
            beat_q   <= '0;
          end
        end
        RD_DATA: begin
          if (bus.rready) beat_q <= beat_q + 9'd1;
        end
        WR_DATA: begin
          if (bus.wvalid) begin
            if (bus.wlast && !at_len) status_q <= RESP_SLVERR;
            // Saturate so surplus beats can never wrap back into the legal range.
            if (beat_q != '1) beat_q <= beat_q + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (bus.wstrb[b]) mem[mem_idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_line_mem_responder.sv
// Self-checking bench for axi_line_mem_responder: directed scenarios plus randomized traffic against a word-array model.
module tb_axi_line_mem_responder;
  localparam int MEM_WORDS = 1024 * 16 / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_line_mem_responder_if bus();
  axi_line_mem_responder dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int fails  = 0;
  int stall_cycles;
  logic [63:0] ref_mem [MEM_WORDS];
  logic [63:0] r_data [$];
  logic [1:0]  r_resp [$];
  logic        r_last [$];
  logic [2:0]  r_id   [$];
  logic [63:0] w_data [$];
  logic [7:0]  w_strb [$];
  logic [2:0]  b_id_got;
  logic [1:0]  b_resp_got;

  // Spec-level response rule: out-of-range anywhere in the burst beats a bad size/burst type.
  function automatic logic [1:0] exp_resp(input logic [31:0] addr, input int len,
                                          input logic [2:0] size, input logic [1:0] burst);
    longint last_word;
    last_word = longint'(addr / 8) + len;
    if (last_word >= MEM_WORDS) return 2'b11;
    if (size != 3'd3 || burst != 2'b01) return 2'b10;
    return 2'b00;
  endfunction

  // Applies the queued W beats to the model and returns the expected B response.
  function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                             input int wlast_at, input logic [1:0] resp);
    int idx;
    for (int k = 0; k <= wlast_at; k++) begin
      if (resp == 2'b00 && k <= len && !(k == wlast_at && k != len)) begin
        idx = int'(addr / 8) + k;
        for (int b = 0; b < 8; b++)
          if (w_strb[k][b]) ref_mem[idx][b*8 +: 8] = w_data[k][b*8 +: 8];
      end
    end
    return (wlast_at != len) ? 2'b10 : resp;
  endfunction

  task automatic idle_inputs();
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.rready = 1'b0; bus.bready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_ar(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
  endtask

  task automatic drive_aw(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
  endtask

  task automatic wait_ar_hs(output int waited);
    waited = 0; #1;
    while (bus.arready !== 1'b1 && waited < 50) begin @(negedge clk); #1; waited++; end
    checks++;
    if (bus.arready !== 1'b1) begin fails++; $display("[TB] FAIL ar_handshake: arready=%b after %0d cycles, required 1", bus.arready, waited); end
    @(negedge clk); bus.arvalid = 1'b0;
  endtask

  task automatic wait_aw_hs(output int waited);
    waited = 0; #1;
    while (bus.awready !== 1'b1 && waited < 50) begin @(negedge clk); #1; waited++; end
    checks++;
    if (bus.awready !== 1'b1) begin fails++; $display("[TB] FAIL aw_handshake: awready=%b after %0d cycles, required 1", bus.awready, waited); end
    @(negedge clk); bus.awvalid = 1'b0;
  endtask

  // mode 0: rready always high, 1: random rready, 2: rready pattern 1,0,0,1 then high.
  task automatic collect_r(input int mode);
    logic [3:0]  pat;
    logic [69:0] held, now;
    bit          prev_stall, done;
    int          cyc;
    pat = 4'b1001;
    r_data.delete(); r_resp.delete(); r_last.delete(); r_id.delete();
    stall_cycles = 0; prev_stall = 0; done = 0; cyc = 0; held = '0;
    while (!done && cyc < 200) begin
      bus.rready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (cyc < 4 ? pat[cyc] : 1'b1);
      #1;
      if (bus.awvalid) begin
        checks++;
        if (bus.awready !== 1'b0) begin fails++; $display("[TB] FAIL aw_blocked_in_read: awready=%b required 0", bus.awready); end
      end
      if (bus.rvalid === 1'b1) begin
        now = {bus.rdata, bus.rresp, bus.rlast, bus.rid};
        if (prev_stall) begin
          checks++;
          if (now !== held) begin fails++; $display("[TB] FAIL r_hold: got %h required %h", now, held); end
        end
        if (bus.rready) begin
          r_data.push_back(bus.rdata); r_resp.push_back(bus.rresp);
          r_last.push_back(bus.rlast); r_id.push_back(bus.rid);
          if (bus.rlast) done = 1;
          prev_stall = 0;
        end else begin
          prev_stall = 1; held = now; stall_cycles++;
        end
      end
      @(negedge clk); cyc++;
    end
    bus.rready = 1'b0;
    checks++;
    if (!done) begin fails++; $display("[TB] FAIL r_timeout: rlast handshake not seen in %0d cycles", cyc); end
  endtask

  task automatic send_w(input int wlast_at);
    int n;
    for (int k = 0; k <= wlast_at; k++) begin
      bus.wdata = w_data[k]; bus.wstrb = w_strb[k]; bus.wlast = (k == wlast_at); bus.wvalid = 1'b1;
      n = 0; #1;
      while (bus.wready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
      checks++;
      if (bus.wready !== 1'b1) begin fails++; $display("[TB] FAIL w_timeout: beat %0d wready=%b required 1", k, bus.wready); end
      if (bus.arvalid) begin
        checks++;
        if (bus.arready !== 1'b0) begin fails++; $display("[TB] FAIL ar_blocked_in_write: arready=%b required 0", bus.arready); end
      end
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic collect_b();
    int n;
    bus.bready = 1'b1; n = 0; #1;
    while (bus.bvalid !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    checks++;
    if (bus.bvalid !== 1'b1) begin fails++; $display("[TB] FAIL b_timeout: bvalid=%b required 1", bus.bvalid); end
    b_id_got = bus.bid; b_resp_got = bus.bresp;
    @(negedge clk); bus.bready = 1'b0;
  endtask

  task automatic write_burst(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int wlast_at);
    int wc;
    drive_aw(id, addr, len, size, burst);
    wait_aw_hs(wc);
    send_w(wlast_at);
    collect_b();
  endtask

  task automatic read_burst(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode);
    int wc;
    drive_ar(id, addr, len, size, burst);
    wait_ar_hs(wc);
    collect_r(mode);
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.arvalid = 1'b1; bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.rready = 1'b1; bus.bready = 1'b1;
    #1;
    checks++; if (bus.arready !== 1'b0) begin fails++; $display("[TB] FAIL rst_arready: got %b required 0", bus.arready); end
    checks++; if (bus.awready !== 1'b0) begin fails++; $display("[TB] FAIL rst_awready: got %b required 0", bus.awready); end
    checks++; if (bus.wready !== 1'b0) begin fails++; $display("[TB] FAIL rst_wready: got %b required 0", bus.wready); end
    checks++; if (bus.rvalid !== 1'b0) begin fails++; $display("[TB] FAIL rst_rvalid: got %b required 0", bus.rvalid); end
    checks++; if (bus.rlast !== 1'b0) begin fails++; $display("[TB] FAIL rst_rlast: got %b required 0", bus.rlast); end
    checks++; if (bus.bvalid !== 1'b0) begin fails++; $display("[TB] FAIL rst_bvalid: got %b required 0", bus.bvalid); end
    checks++; if ({bus.rid, bus.rresp, bus.bid, bus.bresp} !== 10'd0) begin fails++; $display("[TB] FAIL rst_ids_resps: got %h required 0", {bus.rid, bus.rresp, bus.bid, bus.bresp}); end
    checks++; if (bus.rdata !== 64'd0) begin fails++; $display("[TB] FAIL rst_rdata: got %h required 0", bus.rdata); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int wc;
    w_data.delete(); w_strb.delete();
    w_data.push_back(64'h1111); w_data.push_back(64'h2222);
    w_strb.push_back(8'hFF);    w_strb.push_back(8'hFF);
    void'(model_write(32'h100, 1, 1, 2'b00));
    drive_aw(3'd5, 32'h100, 8'd1, 3'd3, 2'b01);
    wait_aw_hs(wc);
    checks++; if (wc !== 0) begin fails++; $display("[TB] FAIL wr_aw_latency: waited %0d cycles required 0", wc); end
    #1;
    checks++; if (bus.wready !== 1'b1) begin fails++; $display("[TB] FAIL wr_wready_next_cycle: got %b required 1", bus.wready); end
    send_w(1);
    #1;
    checks++; if (bus.bvalid !== 1'b1) begin fails++; $display("[TB] FAIL wr_bvalid_next_cycle: got %b required 1", bus.bvalid); end
    collect_b();
    checks++; if (b_id_got !== 3'd5) begin fails++; $display("[TB] FAIL wr_bid: got %0d required 5", b_id_got); end
    checks++; if (b_resp_got !== 2'b00) begin fails++; $display("[TB] FAIL wr_bresp: got %b required 00", b_resp_got); end

    drive_ar(3'd5, 32'h100, 8'd1, 3'd3, 2'b01);
    wait_ar_hs(wc);
    #1;
    checks++; if (bus.rvalid !== 1'b1) begin fails++; $display("[TB] FAIL rd_first_rvalid: got %b required 1", bus.rvalid); end
    collect_r(0);
    checks++; if (r_data.size() !== 2) begin fails++; $display("[TB] FAIL rd_beats: got %0d required 2", r_data.size()); end
    if (r_data.size() == 2) begin
      checks++; if (r_data[0] !== 64'h1111 || r_data[1] !== 64'h2222) begin fails++; $display("[TB] FAIL rd_data: got %h %h required 1111 2222", r_data[0], r_data[1]); end
      checks++; if ({r_last[0], r_last[1]} !== 2'b01) begin fails++; $display("[TB] FAIL rd_rlast: got %b%b required 01", r_last[0], r_last[1]); end
      checks++; if (r_id[0] !== 3'd5 || r_id[1] !== 3'd5 || r_resp[0] !== 2'b00 || r_resp[1] !== 2'b00) begin fails++; $display("[TB] FAIL rd_id_resp: got id %0d/%0d resp %b/%b required 5/5 00/00", r_id[0], r_id[1], r_resp[0], r_resp[1]); end
    end
  endtask

  task automatic test_partial_strobe();
    w_data.delete(); w_strb.delete();
    w_data.push_back(64'hFFFF_FFFF_FFFF_FFFF); w_strb.push_back(8'hFF);
    write_burst(3'd1, 32'h200, 8'd0, 3'd3, 2'b01, 0);
    w_data.delete(); w_strb.delete();
    w_data.push_back(64'h0); w_strb.push_back(8'h0F);
    write_burst(3'd1, 32'h200, 8'd0, 3'd3, 2'b01, 0);
    read_burst(3'd1, 32'h200, 8'd0, 3'd3, 2'b01, 0);
    checks++; if (r_data.size() !== 1 || r_data[0] !== 64'hFFFF_FFFF_0000_0000) begin fails++; $display("[TB] FAIL strobe_merge: got %h required ffffffff00000000", r_data[0]); end
  endtask

  task automatic test_backpressure();
    read_burst(3'd6, 32'h100, 8'd1, 3'd3, 2'b01, 2);
    checks++; if (r_data.size() !== 2) begin fails++; $display("[TB] FAIL bp_beats: got %0d required 2", r_data.size()); end
    checks++; if (stall_cycles !== 2) begin fails++; $display("[TB] FAIL bp_stalls: got %0d required 2", stall_cycles); end
    checks++; if (r_data[0] !== 64'h1111 || r_data[1] !== 64'h2222 || r_last[1] !== 1'b1) begin fails++; $display("[TB] FAIL bp_data: got %h %h last %b required 1111 2222 last 1", r_data[0], r_data[1], r_last[1]); end
  endtask

  task automatic test_errors();
    read_burst(3'd2, 32'd16384, 8'd1, 3'd3, 2'b01, 0);
    checks++; if (r_data.size() !== 2 || r_resp[0] !== 2'b11 || r_resp[1] !== 2'b11 || r_data[0] !== 64'd0 || r_data[1] !== 64'd0) begin fails++; $display("[TB] FAIL err_decerr_read: beats %0d resp %b/%b data %h/%h required 2 11/11 0/0", r_data.size(), r_resp[0], r_resp[1], r_data[0], r_data[1]); end
    read_burst(3'd2, 32'h100, 8'd1, 3'd2, 2'b01, 0);
    checks++; if (r_data.size() !== 2 || r_resp[0] !== 2'b10 || r_resp[1] !== 2'b10 || r_data[0] !== 64'd0) begin fails++; $display("[TB] FAIL err_size_read: beats %0d resp %b/%b data %h required 2 10/10 0", r_data.size(), r_resp[0], r_resp[1], r_data[0]); end
    read_burst(3'd2, 32'h100, 8'd0, 3'd3, 2'b10, 0);
    checks++; if (r_resp[0] !== 2'b10) begin fails++; $display("[TB] FAIL err_wrap_read: got %b required 10", r_resp[0]); end

    // Last legal word, and the same start with a burst running one word past the array.
    w_data.delete(); w_strb.delete();
    w_data.push_back(64'hABCD_0123_4567_89EF); w_strb.push_back(8'hFF);
    write_burst(3'd3, 32'h3FF8, 8'd0, 3'd3, 2'b01, 0);
    checks++; if (b_resp_got !== 2'b00) begin fails++; $display("[TB] FAIL edge_write_bresp: got %b required 00", b_resp_got); end
    read_burst(3'd3, 32'h3FF8, 8'd0, 3'd3, 2'b01, 0);
    checks++; if (r_resp[0] !== 2'b00 || r_data[0] !== 64'hABCD_0123_4567_89EF) begin fails++; $display("[TB] FAIL edge_read: resp %b data %h required 00 abcd0123456789ef", r_resp[0], r_data[0]); end
    read_burst(3'd3, 32'h3FF8, 8'd1, 3'd3, 2'b01, 0);
    checks++; if (r_data.size() !== 2 || r_resp[0] !== 2'b11 || r_data[0] !== 64'd0) begin fails++; $display("[TB] FAIL edge_cross_read: beats %0d resp %b data %h required 2 11 0", r_data.size(), r_resp[0], r_data[0]); end

    w_data.delete(); w_strb.delete();
    w_data.push_back(64'hAAAA); w_data.push_back(64'hBBBB);
    w_strb.push_back(8'hFF);    w_strb.push_back(8'hFF);
    write_burst(3'd4, 32'h300, 8'd1, 3'd3, 2'b01, 1);
    w_data.delete(); w_strb.delete();
    w_data.push_back(64'hCCCC); w_strb.push_back(8'hFF);
    write_burst(3'd4, 32'h300, 8'd1, 3'd3, 2'b01, 0);
    checks++; if (b_resp_got !== 2'b10 || b_id_got !== 3'd4) begin fails++; $display("[TB] FAIL err_short_write: bresp %b bid %0d required 10 4", b_resp_got, b_id_got); end
    read_burst(3'd4, 32'h300, 8'd1, 3'd3, 2'b01, 0);
    checks++; if (r_data[0] !== 64'hAAAA || r_data[1] !== 64'hBBBB) begin fails++; $display("[TB] FAIL err_short_write_untouched: got %h %h required aaaa bbbb", r_data[0], r_data[1]); end
  endtask

  task automatic test_collision();
    bit exp_second_read;
    int wc;
`ifdef AXI_LINE_MEM_RR_ARB_EN
    exp_second_read = 1'b0;
`else
    exp_second_read = 1'b1;
`endif
    do_reset();
    w_data.delete(); w_strb.delete();
    w_data.push_back(64'h5A5A_5A5A); w_strb.push_back(8'hFF);
    drive_ar(3'd1, 32'h100, 8'd1, 3'd3, 2'b01);
    drive_aw(3'd2, 32'h400, 8'd0, 3'd3, 2'b01);
    #1;
    checks++; if ({bus.arready, bus.awready} !== 2'b10) begin fails++; $display("[TB] FAIL coll1_grant: ar/aw ready %b%b required 10", bus.arready, bus.awready); end
    wait_ar_hs(wc);
    collect_r(0);
    checks++; if (r_data.size() !== 2 || r_data[0] !== 64'h1111 || r_id[0] !== 3'd1) begin fails++; $display("[TB] FAIL coll1_read: beats %0d data %h id %0d required 2 1111 1", r_data.size(), r_data[0], r_id[0]); end

    drive_ar(3'd3, 32'h100, 8'd0, 3'd3, 2'b01);
    #1;
    checks++; if ({bus.arready, bus.awready} !== {exp_second_read, !exp_second_read}) begin fails++; $display("[TB] FAIL coll2_grant: ar/aw ready %b%b required %b%b", bus.arready, bus.awready, exp_second_read, !exp_second_read); end
    if (bus.arready === 1'b1) begin
      wait_ar_hs(wc); collect_r(0);
      wait_aw_hs(wc); send_w(0); collect_b();
    end else begin
      wait_aw_hs(wc); send_w(0); collect_b();
      wait_ar_hs(wc); collect_r(0);
    end
    checks++; if (b_resp_got !== 2'b00 || b_id_got !== 3'd2) begin fails++; $display("[TB] FAIL coll_write_resp: bresp %b bid %0d required 00 2", b_resp_got, b_id_got); end
    checks++; if (r_data.size() !== 1 || r_data[0] !== 64'h1111 || r_id[0] !== 3'd3) begin fails++; $display("[TB] FAIL coll2_read: beats %0d data %h id %0d required 1 1111 3", r_data.size(), r_data[0], r_id[0]); end
    void'(model_write(32'h400, 0, 0, 2'b00));
  endtask

  task automatic test_reset_mid_read();
    int wc;
    drive_ar(3'd7, 32'h100, 8'd3, 3'd3, 2'b01);
    wait_ar_hs(wc);
    bus.rready = 1'b1;
    #1;
    checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 64'h1111) begin fails++; $display("[TB] FAIL mid_rst_first_beat: rvalid %b data %h required 1 1111", bus.rvalid, bus.rdata); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.rvalid !== 1'b0 || bus.rlast !== 1'b0 || bus.rdata !== 64'd0) begin fails++; $display("[TB] FAIL mid_rst_outputs: rvalid %b rlast %b data %h required 0 0 0", bus.rvalid, bus.rlast, bus.rdata); end
    @(negedge clk);
    rst = 1'b0; bus.rready = 1'b0;
    @(negedge clk);
    read_burst(3'd7, 32'h100, 8'd1, 3'd3, 2'b01, 0);
    checks++; if (r_data.size() !== 2 || r_data[0] !== 64'h1111 || r_data[1] !== 64'h2222) begin fails++; $display("[TB] FAIL mid_rst_next_read: beats %0d data %h %h required 2 1111 2222", r_data.size(), r_data[0], r_data[1]); end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [2:0]  id;
    logic [1:0]  burst, resp, exp_b;
    int          len, bad;
    // Fully initialise a 64-word window so every random read has a known expectation.
    w_data.delete(); w_strb.delete();
    for (int k = 0; k < 64; k++) begin w_data.push_back({$urandom, $urandom}); w_strb.push_back(8'hFF); end
    exp_b = model_write(32'h2000, 63, 63, 2'b00);
    write_burst(3'd0, 32'h2000, 8'd63, 3'd3, 2'b01, 63);
    checks++; if (b_resp_got !== exp_b) begin fails++; $display("[TB] FAIL rand_init_bresp: got %b required %b", b_resp_got, exp_b); end
    for (int it = 0; it < 40; it++) begin
      addr  = 32'h2000 + 32'($urandom_range(0, 60)) * 8;
      len   = $urandom_range(0, 3);
      id    = 3'($urandom_range(0, 7));
      burst = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'b01;
      resp  = exp_resp(addr, len, 3'd3, burst);
      if ($urandom_range(0, 1) == 1) begin
        w_data.delete(); w_strb.delete();
        for (int k = 0; k <= len; k++) begin w_data.push_back({$urandom, $urandom}); w_strb.push_back(8'($urandom)); end
        exp_b = model_write(addr, len, len, resp);
        write_burst(id, addr, 8'(len), 3'd3, burst, len);
        checks++; if (b_resp_got !== exp_b || b_id_got !== id) begin fails++; $display("[TB] FAIL rand_write_%0d: bresp %b bid %0d required %b %0d", it, b_resp_got, b_id_got, exp_b, id); end
      end else begin
        read_burst(id, addr, 8'(len), 3'd3, burst, 1);
        checks++; if (r_data.size() !== len + 1) begin fails++; $display("[TB] FAIL rand_read_beats_%0d: got %0d required %0d", it, r_data.size(), len + 1); end
        bad = 0;
        for (int k = 0; k < r_data.size() && k <= len; k++) begin
          if (r_data[k] !== ((resp == 2'b00) ? ref_mem[int'(addr / 8) + k] : 64'd0) || r_resp[k] !== resp ||
              r_last[k] !== (k == len) || r_id[k] !== id) bad++;
        end
        checks++; if (bad != 0) begin fails++; $display("[TB] FAIL rand_read_%0d: %0d bad beats at addr %h len %0d", it, bad, addr, len); end
      end
    end
  endtask

  initial begin
    idle_inputs();
    #2 rst = 1'b1;
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_backpressure();
    test_errors();
    test_collision();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
